fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two and at least 2.
REQ-002 Parameter WIDTH, default 16, instruction and PC width in bits.
REQ-003 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 I_mem_address  output  WIDTH  I-cache request address.
REQ-007 I_mem_read  output  1  I-cache read request, level-held until I_mem_resp.
REQ-008 I_mem_resp  input  1  one-cycle I-cache completion; I_mem_rdata is valid in the same cycle.
REQ-009 I_mem_rdata  input  WIDTH  fetched instruction.
REQ-010 redirect  input  1  taken branch, jump or trap from writeback; flushes the queue.
REQ-011 redirect_pc  input  WIDTH  new fetch address, sampled when redirect=1.
REQ-012 out_valid  output  1  the queue head holds an instruction.
REQ-013 out_ready  input  1  decode accepts the head this cycle.
REQ-014 out_ir  output  WIDTH  head instruction.
REQ-015 out_pc  output  WIDTH  head PC+2, matching the pc_id convention.
REQ-016 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 The FSM SHALL have three states: IDLE (no request), FETCH (request outstanding), DISCARD (request outstanding, response to be dropped).
REQ-018 The block SHALL register I_mem_address (req_addr) at issue and hold it stable until I_mem_resp; I_mem_read=1 exactly in FETCH and DISCARD.
REQ-019 From IDLE, with redirect=0 and count<DEPTH, the FSM SHALL go to FETCH with req_addr=fetch_pc.
REQ-020 In FETCH with I_mem_resp=1 and redirect=0, the block SHALL push {req_addr+2, I_mem_rdata} and set fetch_pc=req_addr+2.
REQ-021 In that cycle the FSM SHALL stay in FETCH with the new req_addr if occupancy after the push and any pop is below DEPTH, and otherwise go to IDLE; back-to-back fetches give one instruction per cache response.
REQ-022 Occupancy SHALL never exceed DEPTH; a request is issued only when a free slot is guaranteed at response time.
REQ-023 A pop SHALL occur when out_valid and out_ready are both 1; the head advances on the next edge.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-025 A pushed entry SHALL become visible as out_valid=1 on the cycle after I_mem_resp (one-cycle latency); the queue has no bypass path.
REQ-026 out_valid SHALL equal (count!=0); out_ir and out_pc SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 A redirect SHALL take priority over push and pop: count=0, pointers cleared, and fetch_pc=redirect_pc on the next edge.
REQ-028 A redirect in FETCH without I_mem_resp SHALL move the FSM to DISCARD; req_addr and I_mem_read stay unchanged, because the cache cannot abort.
REQ-029 On I_mem_resp in DISCARD, the data SHALL be dropped and the FSM SHALL go to FETCH at fetch_pc.
REQ-030 A redirect in the same cycle as I_mem_resp in FETCH SHALL drop the data; the next state is FETCH at redirect_pc.
REQ-031 A redirect in DISCARD SHALL update fetch_pc only; the state is unchanged.
REQ-032 A redirect in IDLE SHALL go to FETCH at redirect_pc.
REQ-033 All PC arithmetic SHALL be modulo 2^WIDTH; 16'hFFFE+2 wraps to 16'h0000.
REQ-034 Pointers SHALL be $clog2(DEPTH) bits wide and wrap naturally.

Reset
REQ-035 On reset=0, asynchronously: state=IDLE, I_mem_read=0, req_addr=RESET_PC, fetch_pc=RESET_PC, count=0, out_valid=0, pointers=0.
REQ-036 The storage array SHALL not be reset; out_ir and out_pc are don't-care while out_valid=0.
REQ-037 Reset asserted mid-request SHALL abandon the request; the first request after reset deassertion targets RESET_PC.

Structure
REQ-038 The fetch state enum and the queue entry struct {pc, ir} SHALL be defined in lc3b_types; DEPTH remains a module parameter.
REQ-039 Storage with its pointers and count SHALL be one sub-module, fifo_buf, parametrised by DEPTH and entry width; the FSM and PC logic live in fetch_queue.

Verification
REQ-040 Reset release, resp every 2 cycles, out_ready=1 -> requests at 0000, 0002, 0004; out_pc sequence 0002, 0004, 0006.
REQ-041 out_ready=0, DEPTH=4, resp one cycle after each read -> exactly 4 pushes, count=4, I_mem_read=0; one pop then resumes fetch at 0008.
REQ-042 Redirect to 0x3000 while FETCH at 0x0004 awaits resp -> DISCARD, address stays 0x0004, resp dropped; next request is 0x3000, count=0.
REQ-043 Redirect to 0x4000 in the same cycle as resp -> data not pushed; next request is 0x4000.
REQ-044 Redirect to 0xFFFE, then two responses -> out_pc values 0000 then 0002 (wrap).
REQ-045 Assert reset for one cycle mid-FETCH with count=3 -> I_mem_read=0 and count=0 immediately; first request after release is RESET_PC.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the instruction fetch path: fetch FSM states and queue entry layout.
package lc3b_types;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] ir;
  } fq_entry_t;

endpackage

// File: rtl/fifo_buf.sv
// Circular buffer with pointers and occupancy count; clear wins over push and pop.
module fifo_buf
  import lc3b_types::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is deliberately left unreset; contents only matter while count != 0.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch FSM feeding a small prefetch queue; one outstanding I-cache request at most.
module fetch_queue
  import lc3b_types::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [WIDTH-1:0]           I_mem_address,
  output logic                       I_mem_read,
  input  logic                       I_mem_resp,
  input  logic [WIDTH-1:0]           I_mem_rdata,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_ir,
  output logic [WIDTH-1:0]           out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int         CW      = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_t     state;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] seq_pc;
  logic             push;
  logic             pop;
  logic [CW:0]      occ_after;
  logic             room_now;
  logic             room_after;

  assign seq_pc     = req_addr + WIDTH'(2);
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready && !redirect;
  assign push       = (state == FETCH) && I_mem_resp && !redirect;
  assign occ_after  = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign room_now   = ({1'b0, count} < DEPTH_C);
  assign room_after = (occ_after < DEPTH_C);

  assign I_mem_address = req_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      I_mem_read <= 1'b0;
      req_addr   <= RESET_PC;
      fetch_pc   <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect) begin
            state      <= FETCH;
            I_mem_read <= 1'b1;
            req_addr   <= redirect_pc;
            fetch_pc   <= redirect_pc;
          end else if (room_now) begin
            state      <= FETCH;
            I_mem_read <= 1'b1;
            req_addr   <= fetch_pc;
          end
        end
        FETCH: begin
          if (redirect && I_mem_resp) begin
            req_addr <= redirect_pc;
            fetch_pc <= redirect_pc;
          end else if (redirect) begin
            // The cache cannot abort, so keep the request up and drop its answer.
            state    <= DISCARD;
            fetch_pc <= redirect_pc;
          end else if (I_mem_resp) begin
            fetch_pc <= seq_pc;
            if (room_after) begin
              req_addr <= seq_pc;
            end else begin
              state      <= IDLE;
              I_mem_read <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (I_mem_resp) begin
            state    <= FETCH;
            req_addr <= redirect ? redirect_pc : fetch_pc;
            if (redirect) fetch_pc <= redirect_pc;
          end else if (redirect) begin
            fetch_pc <= redirect_pc;
          end
        end
        default: begin
          state      <= IDLE;
          I_mem_read <= 1'b0;
        end
      endcase
    end
  end

  // Entry layout matches fq_entry_t: {pc, ir}.
  fifo_buf #(
    .DEPTH (DEPTH),
    .DATA_W(2*WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clear    (redirect),
    .push     (push),
    .pop      (pop),
    .push_data({seq_pc, I_mem_rdata}),
    .head_data({out_pc, out_ir}),
    .count    (count)
  );

endmodule
